// File: rtl/flit_injector.sv
// flit_injector: local FIFO in front of a credit-based router input port.
// Flits from the core are queued, then sent one per cycle while the injector
// holds downstream credits. Each credit is one free slot in the router's buffer.
module flit_injector #(
    parameter int FW = 36,
    parameter int B  = 4,
    parameter int D  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [FW-1:0]            in_flit,
    output logic                     in_ready,
    output logic                     flit_out_wr,
    output logic [FW-1:0]            flit_out,
    input  logic                     credit_in,
    output logic [$clog2(B+1)-1:0]   credit_cnt,
    output logic [$clog2(D+1)-1:0]   fifo_cnt,
    output logic                     credit_err
);

    localparam int CW = $clog2(B+1);
    localparam int DW = $clog2(D+1);
    localparam int PW = $clog2(D);

    logic [FW-1:0] mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          accept;
    logic          send;

    // Full is decided from registered occupancy only, so a pop in the same
    // cycle never opens a slot for a push when the FIFO is full.
    assign in_ready = (fifo_cnt != DW'(D));
    assign accept   = in_valid && in_ready;
    assign send     = (fifo_cnt != '0) && (credit_cnt != '0);

    // Storage: no reset needed, occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_flit;
    end

    // Pointers wrap naturally because D is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (send)
                rd_ptr <= rd_ptr + PW'(1);
            case ({accept, send})
                2'b10:   fifo_cnt <= fifo_cnt + DW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - DW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Registered output stage: one write strobe per send, data held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_out_wr <= 1'b0;
            flit_out    <= '0;
        end else begin
            flit_out_wr <= send;
            if (send)
                flit_out <= mem[rd_ptr];
        end
    end

    // Credit accounting: a send and a returned credit in the same cycle cancel.
    // A credit arriving with the counter already full is a protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= CW'(B);
            credit_err <= 1'b0;
        end else begin
            if (send && !credit_in) begin
                credit_cnt <= credit_cnt - CW'(1);
            end else if (!send && credit_in) begin
                if (credit_cnt == CW'(B))
                    credit_err <= 1'b1;
                else
                    credit_cnt <= credit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: scenario tasks with inline checks, plus a
// scoreboard queue that tracks accepted flits and checks the output stream.
module tb_flit_injector;

    localparam int FW = 36;
    localparam int B  = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [FW-1:0] in_flit;
    logic          in_ready;
    logic          flit_out_wr;
    logic [FW-1:0] flit_out;
    logic          credit_in;
    logic [2:0]    credit_cnt;
    logic [2:0]    fifo_cnt;
    logic          credit_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [FW-1:0] exp_q [$];

    flit_injector #(.FW(FW), .B(B), .D(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .in_ready   (in_ready),
        .flit_out_wr(flit_out_wr),
        .flit_out   (flit_out),
        .credit_in  (credit_in),
        .credit_cnt (credit_cnt),
        .fifo_cnt   (fifo_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge+1; record accepted flits at negedge+3.
    always begin
        @(negedge clk);
        #3;
        if (rst)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(in_flit);
    end

    // Every write strobe must carry the oldest outstanding flit.
    always @(negedge clk) begin
        if (!rst && flit_out_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_wr got flit %0h exp no write", flit_out);
            end else begin
                if (flit_out !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL sb_order got %0h exp %0h", flit_out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [FW-1:0] rnd_flit();
        return FW'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; credit_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (flit_out_wr !== 1'b0 || flit_out !== '0 || credit_cnt !== 3'd4 ||
                fifo_cnt !== 3'd0 || credit_err !== 1'b0 || in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_vals got wr=%0b out=%0h cr=%0d fc=%0d err=%0b rdy=%0b exp 0 0 4 0 0 1",
                         flit_out_wr, flit_out, credit_cnt, fifo_cnt, credit_err, in_ready);
            end
        end
        #1 rst = 1'b0;
    endtask

    // Four flits back to back, no credit returns: four consecutive strobes.
    task automatic test_back_to_back();
        for (int k = 0; k < 7; k++) begin
            in_valid = (k < 4);
            in_flit  = rnd_flit();
            @(negedge clk);
            n_checks++;
            if (flit_out_wr !== (k >= 1 && k <= 4)) begin
                n_errors++;
                $display("FAIL b2b_wr cyc %0d got %0b exp %0b", k, flit_out_wr, (k >= 1 && k <= 4));
            end
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (credit_cnt !== 3'd0 || fifo_cnt !== 3'd0) begin
            n_errors++;
            $display("FAIL b2b_end got cr=%0d fc=%0d exp 0 0", credit_cnt, fifo_cnt);
        end
    endtask

    // No credits: fill the FIFO, refuse an extra push, then one credit frees one flit.
    task automatic test_stall();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_flit  = rnd_flit();
            @(negedge clk);
            n_checks++;
            if (flit_out_wr !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_wr cyc %0d got %0b exp 0", k, flit_out_wr);
            end
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || fifo_cnt !== 3'd4) begin
            n_errors++;
            $display("FAIL stall_full got rdy=%0b fc=%0d exp 0 4", in_ready, fifo_cnt);
        end
        credit_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flit_out_wr !== 1'b0 || credit_cnt !== 3'd1) begin
            n_errors++;
            $display("FAIL stall_credit got wr=%0b cr=%0d exp 0 1", flit_out_wr, credit_cnt);
        end
        #1 credit_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flit_out_wr !== 1'b1 || fifo_cnt !== 3'd3 || in_ready !== 1'b1 || credit_cnt !== 3'd0) begin
            n_errors++;
            $display("FAIL stall_release got wr=%0b fc=%0d rdy=%0b cr=%0d exp 1 3 1 0",
                     flit_out_wr, fifo_cnt, in_ready, credit_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (flit_out_wr !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_single got wr=%0b exp 0", flit_out_wr);
        end
        #1;
    endtask

    // Credit returned in the same cycle as a send leaves the count unchanged.
    task automatic test_credit_same_cycle();
        credit_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (credit_cnt !== 3'd1 || flit_out_wr !== 1'b0) begin
            n_errors++;
            $display("FAIL same_pre got cr=%0d wr=%0b exp 1 0", credit_cnt, flit_out_wr);
        end
        #1 credit_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flit_out_wr !== 1'b1 || credit_cnt !== 3'd1 || fifo_cnt !== 3'd2) begin
            n_errors++;
            $display("FAIL same_cycle got wr=%0b cr=%0d fc=%0d exp 1 1 2", flit_out_wr, credit_cnt, fifo_cnt);
        end
        #1 credit_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flit_out_wr !== 1'b1 || credit_cnt !== 3'd0 || fifo_cnt !== 3'd1) begin
            n_errors++;
            $display("FAIL same_next got wr=%0b cr=%0d fc=%0d exp 1 0 1", flit_out_wr, credit_cnt, fifo_cnt);
        end
        #1;
        // Drain the last flit and refill credits to B.
        credit_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
        end
        credit_in = 1'b0;
        n_checks++;
        if (credit_cnt !== 3'd4 || fifo_cnt !== 3'd0 || credit_err !== 1'b0) begin
            n_errors++;
            $display("FAIL same_refill got cr=%0d fc=%0d err=%0b exp 4 0 0", credit_cnt, fifo_cnt, credit_err);
        end
    endtask

    // Credit while already full and idle: saturate and raise the sticky error.
    task automatic test_overflow();
        credit_in = 1'b1;
        @(negedge clk);
        #1 credit_in = 1'b0;
        n_checks++;
        if (credit_err !== 1'b1 || credit_cnt !== 3'd4) begin
            n_errors++;
            $display("FAIL ovf_set got err=%0b cr=%0d exp 1 4", credit_err, credit_cnt);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (credit_err !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky got %0b exp 1", credit_err);
        end
    endtask

    // Ten flits with a credit every cycle: strobes back to back, pointers wrap twice.
    task automatic test_stream();
        for (int k = 0; k < 12; k++) begin
            in_valid  = (k < 10);
            credit_in = (k < 10);
            in_flit   = rnd_flit();
            @(negedge clk);
            n_checks++;
            if (flit_out_wr !== (k >= 1 && k <= 10)) begin
                n_errors++;
                $display("FAIL stream_wr cyc %0d got %0b exp %0b", k, flit_out_wr, (k >= 1 && k <= 10));
            end
            #1;
        end
        in_valid = 1'b0; credit_in = 1'b0;
        n_checks++;
        if (credit_cnt !== 3'd3 || fifo_cnt !== 3'd0 || exp_q.size() != 0 || credit_err !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_end got cr=%0d fc=%0d q=%0d err=%0b exp 3 0 0 1",
                     credit_cnt, fifo_cnt, exp_q.size(), credit_err);
        end
    endtask

    // Reset mid-operation with flits queued: immediate reset values, no strobes after.
    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) begin
            in_valid  = (k < 6);
            credit_in = (k == 6);
            in_flit   = rnd_flit();
            @(negedge clk);
            #1;
        end
        in_valid = 1'b0; credit_in = 1'b0;
        n_checks++;
        if (fifo_cnt !== 3'd3 || credit_cnt !== 3'd1) begin
            n_errors++;
            $display("FAIL rmid_pre got fc=%0d cr=%0d exp 3 1", fifo_cnt, credit_cnt);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (flit_out_wr !== 1'b0 || flit_out !== '0 || credit_cnt !== 3'd4 ||
            fifo_cnt !== 3'd0 || credit_err !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_async got wr=%0b out=%0h cr=%0d fc=%0d err=%0b rdy=%0b exp 0 0 4 0 0 1",
                     flit_out_wr, flit_out, credit_cnt, fifo_cnt, credit_err, in_ready);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (flit_out_wr !== 1'b0 || fifo_cnt !== 3'd0 || credit_cnt !== 3'd4) begin
                n_errors++;
                $display("FAIL rmid_post cyc %0d got wr=%0b fc=%0d cr=%0d exp 0 0 4",
                         k, flit_out_wr, fifo_cnt, credit_cnt);
            end
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_credit_same_cycle();
        test_overflow();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
